// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer for a pipelined 16x16 multiply-accumulate datapath.
// It clears the MAC, streams N operand pairs into it, drains the pipeline and returns the sum.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_CLR   | mac_clr held for CLR_CYC cycles to flush product and accumulator
// S_RUN   | accepting operand pairs, in_ready high
// S_DRAIN | zeros fed while the last pair propagates to mac_acc
// S_DONE  | result presented until accepted
module mac_dot_ctrl #(
    parameter int PIPE_LAT = 2,
    parameter int CLR_CYC  = 2,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_clr,
    input  logic [37:0]      mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [37:0]      res_data,
    output logic             busy
);

    localparam int TMR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   cnt_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [15:0]        mac_a_q;
    logic [15:0]        mac_b_q;
    logic               res_valid_q;
    logic [37:0]        res_data_q;

    logic               cmd_fire;
    logic               in_fire;
    logic               res_fire;
    logic               tmr_done;

    assign cmd_fire = cmd_valid && (state_q == S_IDLE);
    assign in_fire  = in_valid && (state_q == S_RUN);
    assign res_fire = res_valid_q && res_ready;
    assign tmr_done = (tmr_q == '0);
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // Any cycle without an accepted pair feeds zeros, so the accumulator is stall-safe.
            mac_a_q <= '0;
            mac_b_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        len_q   <= cmd_len;
                        cnt_q   <= '0;
                        tmr_q   <= TMR_W'(CLR_CYC - 1);
                        state_q <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (tmr_done) begin
                        if (len_q == '0) begin
                            tmr_q   <= TMR_W'(PIPE_LAT);
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (in_fire) begin
                        mac_a_q <= in_a;
                        mac_b_q <= in_b;
                        cnt_q   <= cnt_d;
                        if (cnt_d == len_q) begin
                            tmr_q   <= TMR_W'(PIPE_LAT);
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last pair sits on mac_a/mac_b in the first drain cycle.
                    if (tmr_done) begin
                        res_data_q  <= mac_acc;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign mac_clr   = reset || (state_q == S_CLR);
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule
